line_window_gen: RTL and testbench

- Streaming 3x3 sliding-window generator for the image filter datapath; parametrised successor to the fixed 8-bank window memory.
- Accepts one raster-order frame over a valid/ready input, buffers two lines internally and emits one 3x3 window per pixel, also raster order, over a valid/ready output.
- Image size, pixel width and border mode are compile-time parameters. Frame start/done handshake replaces the hard-coded bank counters.

---
 rtl/line_window_gen.sv | 167 ++++++++++++++++
 tb/tb_line_window_gen.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/line_window_gen.sv
// line_window_gen: streaming 3x3 sliding-window generator over two circular line buffers.
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-high reset
//   start                      single-cycle frame start pulse, ignored while busy
//   in_valid/in_ready/in_pixel raster-order pixel input handshake
//   out_valid/out_ready        window output handshake
//   win                        packed 3x3 window, element (r,c) at [DATA_W*(3r+c) +: DATA_W]
//   out_x, out_y               centre coordinate of the presented window
//   busy, done                 frame in progress / one-cycle end-of-frame pulse
module line_window_gen #(
    parameter int DATA_W      = 8,
    parameter int IMG_W       = 256,
    parameter int IMG_H       = 256,
    parameter int BORDER_MODE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_pixel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [9*DATA_W-1:0]       win,
    output logic [$clog2(IMG_W)-1:0]  out_x,
    output logic [$clog2(IMG_H)-1:0]  out_y,
    output logic                      busy,
    output logic                      done
);
    localparam int XW   = $clog2(IMG_W);
    localparam int YW   = $clog2(IMG_H);
    localparam int PW   = $clog2(IMG_H + 2);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int CW   = $clog2(NPIX + 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t               state_q, state_d;
    logic [XW-1:0]        px_q, px_d;
    logic [PW-1:0]        py_q, py_d;
    logic                 sel_q, sel_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0]    ca_q [3];
    logic [DATA_W-1:0]    ca_d [3];
    logic [DATA_W-1:0]    cb_q [3];
    logic [DATA_W-1:0]    cb_d [3];
    logic [DATA_W-1:0]    nc [3];
    logic [DATA_W-1:0]    lb0 [IMG_W];
    logic [DATA_W-1:0]    lb1 [IMG_W];
    logic [DATA_W-1:0]    raw [3][3];
    logic [DATA_W-1:0]    cfix [3][3];
    logic [DATA_W-1:0]    w [3][3];
    logic [9*DATA_W-1:0]  wv;
    logic                 out_valid_q, out_valid_d;
    logic [9*DATA_W-1:0]  win_q, win_d;
    logic [XW-1:0]        out_x_q, out_x_d;
    logic [YW-1:0]        out_y_q, out_y_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic                 space, step, load, line_end, go;
    logic [XW-1:0]        nx;
    logic [YW-1:0]        ny;

    // A "step" consumes one raster position: a real pixel in RUN, or a virtual
    // one in FLUSH that pushes the final W+1 windows out of the column pipeline.
    // Each step past position IMG_W completes the window centred one row up and
    // one column left of the step position.
    always_comb begin
        space    = !out_valid_q || out_ready;
        in_ready = state_q == RUN && space;
        step     = (in_ready && in_valid) || (state_q == FLUSH && cnt_q != CW'(NPIX) && space);
        load     = step && (py_q >= PW'(2) || (py_q == PW'(1) && px_q != '0));
        line_end = px_q == XW'(IMG_W - 1);
        go       = state_q == IDLE && start;
        nx = cnt_q == '0 ? '0 : out_x_q == XW'(IMG_W - 1) ? '0 : out_x_q + 1'b1;
        ny = cnt_q == '0 ? '0 : out_x_q != XW'(IMG_W - 1) ? out_y_q :
             out_y_q == YW'(IMG_H - 1) ? '0 : out_y_q + 1'b1;
        // sel_q names the buffer holding the row two above the step row
        nc[0] = sel_q ? lb1[px_q] : lb0[px_q];
        nc[1] = sel_q ? lb0[px_q] : lb1[px_q];
        nc[2] = in_pixel;
        for (int r = 0; r < 3; r++) begin
            raw[r][0]  = ca_q[r];
            raw[r][1]  = cb_q[r];
            raw[r][2]  = nc[r];
            cfix[r][0] = nx == '0 ? (BORDER_MODE != 0 ? raw[r][1] : '0) : raw[r][0];
            cfix[r][1] = raw[r][1];
            cfix[r][2] = nx == XW'(IMG_W - 1) ? (BORDER_MODE != 0 ? raw[r][1] : '0) : raw[r][2];
        end
        // rows are fixed after columns so replicated corners clamp both axes
        for (int c = 0; c < 3; c++) begin
            w[0][c] = ny == '0 ? (BORDER_MODE != 0 ? cfix[1][c] : '0) : cfix[0][c];
            w[1][c] = cfix[1][c];
            w[2][c] = ny == YW'(IMG_H - 1) ? (BORDER_MODE != 0 ? cfix[1][c] : '0) : cfix[2][c];
        end
        wv = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                wv[DATA_W*(3*r+c) +: DATA_W] = w[r][c];
        for (int r = 0; r < 3; r++) begin
            ca_d[r] = step ? cb_q[r] : ca_q[r];
            cb_d[r] = step ? nc[r] : cb_q[r];
        end
        px_d        = go ? '0 : step ? (line_end ? '0 : px_q + 1'b1) : px_q;
        py_d        = go ? '0 : (step && line_end) ? py_q + 1'b1 : py_q;
        sel_d       = go ? 1'b0 : sel_q ^ (step && line_end);
        cnt_d       = go ? '0 : cnt_q + CW'(load);
        out_valid_d = load || (out_valid_q && !out_ready);
        win_d       = load ? wv : win_q;
        out_x_d     = load ? nx : out_x_q;
        out_y_d     = load ? ny : out_y_q;
        state_d = state_q == IDLE  ? (start ? RUN : IDLE) :
                  state_q == RUN   ? ((step && line_end && py_q == PW'(IMG_H - 1)) ? FLUSH : RUN) :
                  state_q == FLUSH ? ((cnt_q == CW'(NPIX) && space) ? DONE : FLUSH) : IDLE;
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk) begin
        if (step) begin
            if (sel_q) lb1[px_q] <= in_pixel;
            else       lb0[px_q] <= in_pixel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            px_q        <= '0;
            py_q        <= '0;
            sel_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            win_q       <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                ca_q[r] <= '0;
                cb_q[r] <= '0;
            end
        end else begin
            state_q     <= state_d;
            px_q        <= px_d;
            py_q        <= py_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            win_q       <= win_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            for (int r = 0; r < 3; r++) begin
                ca_q[r] <= ca_d[r];
                cb_q[r] <= cb_d[r];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign win       = win_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_line_window_gen.sv
// tb_line_window_gen: scoreboard bench driving zero-pad and replicate instances with one 4x3 stream.
module tb_line_window_gen;
    localparam int DW = 8, W = 4, H = 3, N = W * H;

    logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 0;
    logic [DW-1:0] in_pixel = 0;
    logic z_in_ready, z_out_valid, z_busy, z_done;
    logic r_in_ready, r_out_valid, r_busy, r_done;
    logic [9*DW-1:0] z_win, r_win;
    logic [1:0] z_x, z_y, r_x, r_y;

    always #5 clk = ~clk;

    line_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .BORDER_MODE(0)) dz (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(z_in_ready),
        .in_pixel(in_pixel), .out_valid(z_out_valid), .out_ready(out_ready), .win(z_win),
        .out_x(z_x), .out_y(z_y), .busy(z_busy), .done(z_done));

    line_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .BORDER_MODE(1)) dr (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(r_in_ready),
        .in_pixel(in_pixel), .out_valid(r_out_valid), .out_ready(out_ready), .win(r_win),
        .out_x(r_x), .out_y(r_y), .busy(r_busy), .done(r_done));

    typedef struct packed {
        logic [9*DW-1:0] wz;
        logic [9*DW-1:0] wr;
        logic [1:0] x;
        logic [1:0] y;
    } exp_t;

    exp_t q[$];
    int checks = 0, passes = 0, nwin = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] pix(input int x, input int y, input int m);
        if (m == 1) begin
            x = x < 0 ? 0 : x >= W ? W - 1 : x;
            y = y < 0 ? 0 : y >= H ? H - 1 : y;
        end else if (x < 0 || x >= W || y < 0 || y >= H) return '0;
        return DW'(y * W + x + 1);
    endfunction

    function automatic logic [9*DW-1:0] ewin(input int x, input int y, input int m);
        logic [9*DW-1:0] v;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                v[DW*(3*r+c) +: DW] = pix(x + c - 1, y + r - 1, m);
        return v;
    endfunction

    task automatic push_frame();
        exp_t e;
        q.delete();
        nwin = 0;
        for (int k = 0; k < N; k++) begin
            e.wz = ewin(k % W, k / W, 0);
            e.wr = ewin(k % W, k / W, 1);
            e.x  = 2'(k % W);
            e.y  = 2'(k / W);
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && z_out_valid && out_ready) begin
            exp_t e;
            chk("queue_nonempty", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("win_zero", z_win, e.wz);
                chk("win_rep", r_win, e.wr);
                chk("xy_zero", {z_x, z_y}, {e.x, e.y});
                chk("xy_rep", {r_x, r_y}, {e.x, e.y});
            end
            nwin++;
        end
    end

    task automatic src(input int stall, input int inj, input int first, input int npx);
        int b;
        for (int i = 0; i < npx; i++) begin
            in_pixel = DW'(i + 1);
            in_valid = 1;
            b = 0;
            @(negedge clk);
            while (!z_in_ready && b < 50) begin
                @(negedge clk);
                b++;
            end
            chk("in_accept_bound", z_in_ready, 1);
            if (first != 0 && i == 5) chk("pre_first_valid", z_out_valid, 0);
            if (inj != 0 && i == 3) start = 1;
            @(posedge clk); #1;
            start = 0;
            if (first != 0 && i == 5) chk("first_valid", z_out_valid, 1);
            if (stall != 0) begin
                in_valid = 0;
                @(posedge clk); #1;
            end
        end
        in_valid = 0;
    endtask

    task automatic snk(input int bp);
        int b, held;
        out_ready = 1;
        held = 0;
        b = 0;
        while (nwin < N && b < 400) begin
            @(posedge clk); #1;
            b++;
            if (bp != 0 && held == 0 && z_out_valid && z_x == 2'd1 && z_y == 2'd0) begin
                out_ready = 0;
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    chk("bp_hold_win", z_win, ewin(1, 0, 0));
                    chk("bp_hold_xy", {z_x, z_y, z_out_valid}, {2'd1, 2'd0, 1'b1});
                    chk("bp_in_ready", z_in_ready, 0);
                    @(posedge clk); #1;
                end
                out_ready = 1;
                held = 1;
            end
        end
        chk("win_count", nwin, N);
    endtask

    task automatic frame(input int stall, input int bp, input int inj, input int first);
        int b;
        push_frame();
        @(posedge clk); #1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        chk("busy_after_start", z_busy, 1);
        fork
            src(stall, inj, first, N);
            snk(bp);
        join
        b = 0;
        @(negedge clk);
        while (!z_done && b < 50) begin
            @(negedge clk);
            b++;
        end
        chk("done_seen", z_done, 1);
        chk("done_after_all", nwin, N);
        chk("busy_with_done", z_busy, 1);
        @(negedge clk);
        chk("done_pulse", z_done, 0);
        chk("busy_fell", z_busy, 0);
        chk("queue_empty", q.size(), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_z", {z_out_valid, z_in_ready, z_busy, z_done, z_x, z_y, z_win}, '0);
        chk("rst_r", {r_out_valid, r_in_ready, r_busy, r_done, r_x, r_y, r_win}, '0);
        rst = 0;
        frame(0, 0, 0, 1);
        frame(0, 1, 0, 0);
        frame(1, 0, 1, 0);
        push_frame();
        out_ready = 1;
        @(posedge clk); #1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        src(0, 0, 0, 7);
        #2 rst = 1;
        #1;
        chk("midrst_z", {z_out_valid, z_in_ready, z_busy, z_done, z_x, z_y, z_win}, '0);
        chk("midrst_r", {r_out_valid, r_in_ready, r_busy, r_done, r_x, r_y, r_win}, '0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_done_after_abort", {z_done, z_busy}, 2'b00);
        end
        frame(0, 0, 0, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
